// File: rtl/linebuffer_window9_if.sv
// Pixel-stream in / 9x9-window out bundle for linebuffer_window9.
// master = pixel source and window consumer, slave = the window generator.
interface linebuffer_window9_if #(
    parameter int PIX_W = 7
);
    logic                   pix_valid;
    logic                   pix_sof;
    logic [PIX_W-1:0]       pix_data;
    logic                   win_valid;
    logic                   win_last;
    logic [7:0]             win_x;
    logic [7:0]             win_y;
    logic [81*PIX_W-1:0]    xarray_flat;
    logic                   frame_err;

    modport master (
        output pix_valid, pix_sof, pix_data,
        input  win_valid, win_last, win_x, win_y, xarray_flat, frame_err
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data,
        output win_valid, win_last, win_x, win_y, xarray_flat, frame_err
    );
endinterface

// File: rtl/linebuffer_window9.sv
// Streaming 9x9 window generator: 8 column-addressed line stores plus a 9x9 register window.
// Optional macro LB_FRAME_ERR_EN builds the sticky frame_err detector (tied 0 otherwise).
module linebuffer_window9 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    linebuffer_window9_if.slave  bus
);
    localparam int         AW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [7:0] COL_MAX = 8'(IMG_W - 1);
    localparam logic [7:0] ROW_MAX = 8'(IMG_H - 1);
    localparam int         TAP_W   = 8 * PIX_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       col_q, col_d;
    logic [7:0]       row_q, row_d;
    logic             acc;
    logic [7:0]       pcol;
    logic [7:0]       prow;
    logic             win_hit;

    logic             win_valid_q, win_valid_d;
    logic             win_last_q, win_last_d;
    logic [7:0]       win_x_q, win_x_d;
    logic [7:0]       win_y_q, win_y_d;

    logic [PIX_W-1:0] win_q [9][9];
    logic [PIX_W-1:0] win_d [9][9];
    logic [81*PIX_W-1:0] flat;

    // Each entry holds the 8 previous rows at one column; slot j is the oldest-but-j row.
    logic [TAP_W-1:0] mem_q [IMG_W];
    logic [TAP_W-1:0] tap_col;
    logic [AW-1:0]    maddr;

    // Accept decision, pixel position and raster counter advance
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        acc     = 1'b0;
        pcol    = col_q;
        prow    = row_q;
        if (bus.pix_valid) begin
            if (bus.pix_sof) begin
                acc  = 1'b1;
                pcol = '0;
                prow = '0;
            end else if (state_q == ST_ACTIVE) begin
                acc = 1'b1;
            end
        end
        if (acc) begin
            state_d = ST_ACTIVE;
            if (pcol == COL_MAX) begin
                col_d = '0;
                if (prow == ROW_MAX) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    row_d = prow + 8'd1;
                end
            end else begin
                col_d = pcol + 8'd1;
                row_d = prow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign maddr   = pcol[AW-1:0];
    assign tap_col = mem_q[maddr];

    // Read-before-write: the old column feeds the window, the aged column goes back.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem_q[maddr] <= {bus.pix_data, tap_col[TAP_W-1:PIX_W]};
        end
    end

    always_comb begin
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (acc) begin
            for (int r = 0; r < 9; r++) begin
                for (int c = 0; c < 8; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < 8; r++) begin
                win_d[r][8] = tap_col[r*PIX_W +: PIX_W];
            end
            win_d[8][8] = bus.pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 9; r++) begin
                for (int c = 0; c < 9; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            win_q <= win_d;
        end
    end

    // Row gating keeps stale line contents from a restarted frame out of any window
    assign win_hit = acc && (pcol >= 8'd8) && (prow >= 8'd8);

    always_comb begin
        win_valid_d = win_hit;
        win_last_d  = win_hit && (pcol == COL_MAX) && (prow == ROW_MAX);
        win_x_d     = win_hit ? pcol : win_x_q;
        win_y_d     = win_hit ? prow : win_y_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_x_q     <= '0;
            win_y_q     <= '0;
        end else begin
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
        end
    end

    always_comb begin
        flat = '0;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                flat[(r*9 + c)*PIX_W +: PIX_W] = win_q[r][c];
            end
        end
    end

    assign bus.win_valid   = win_valid_q;
    assign bus.win_last    = win_last_q;
    assign bus.win_x       = win_x_q;
    assign bus.win_y       = win_y_q;
    assign bus.xarray_flat = flat;

`ifdef LB_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    always_comb begin
        frame_err_d = frame_err_q;
        if (bus.pix_valid) begin
            if ((state_q == ST_IDLE) && !bus.pix_sof) begin
                frame_err_d = 1'b1;
            end
            if ((state_q == ST_ACTIVE) && bus.pix_sof && ((col_q != '0) || (row_q != '0))) begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_linebuffer_window9.sv
// Scoreboard bench for linebuffer_window9 at 12x10, 7-bit pixels.
// A reference image model predicts each window when its pixel is driven; checks run on the falling edge.
module tb_linebuffer_window9;
    localparam int W  = 12;
    localparam int H  = 10;
    localparam int P  = 7;
    localparam int XW = 81 * P;
`ifdef LB_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0]    x;
        logic [7:0]    y;
        logic          last;
        logic [XW-1:0] data;
    } win_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    linebuffer_window9_if #(.PIX_W(P)) bus ();

    linebuffer_window9 #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_win   = 0;
    int n_last  = 0;

    win_t       sb [$];
    int         m_state;
    int         m_col;
    int         m_row;
    bit         m_err;
    bit         exp_vld;
    bit         exp_last;
    logic [P-1:0] img [H][W];

    task automatic chk(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input bit v, input bit sof, input logic [P-1:0] d);
        int   c;
        int   r;
        win_t w;
        exp_vld  = 1'b0;
        exp_last = 1'b0;
        if (!v) return;
        if (!sof && m_state == 0) begin
            m_err = 1'b1;
            return;
        end
        if (sof) begin
            if (m_state == 1 && (m_col != 0 || m_row != 0)) m_err = 1'b1;
            c = 0;
            r = 0;
        end else begin
            c = m_col;
            r = m_row;
        end
        img[r][c] = d;
        if (c >= 8 && r >= 8) begin
            w.data = '0;
            for (int k = 0; k < 81; k++) begin
                w.data[k*P +: P] = img[r-8+k/9][c-8+k%9];
            end
            w.x    = 8'(c);
            w.y    = 8'(r);
            w.last = (c == W-1) && (r == H-1);
            sb.push_back(w);
            exp_vld  = 1'b1;
            exp_last = w.last;
        end
        m_state = 1;
        if (c == W-1) begin
            m_col = 0;
            if (r == H-1) begin
                m_row   = 0;
                m_state = 0;
            end else begin
                m_row = r + 1;
            end
        end else begin
            m_col = c + 1;
            m_row = r;
        end
    endtask

    task automatic step(input bit v, input bit sof, input logic [P-1:0] d);
        win_t w;
        bus.pix_valid = v;
        bus.pix_sof   = sof;
        bus.pix_data  = d;
        model_accept(v, sof, d);
        @(posedge clk);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        chk("win_valid", XW'(bus.win_valid), XW'(exp_vld));
        chk("win_last", XW'(bus.win_last), XW'(exp_last));
        chk("frame_err", XW'(bus.frame_err), XW'(m_err & ERR_EN));
        if (bus.win_valid) n_win++;
        if (bus.win_valid && bus.win_last) n_last++;
        if (exp_vld && sb.size() > 0) begin
            w = sb.pop_front();
            chk("win_x", XW'(bus.win_x), XW'(w.x));
            chk("win_y", XW'(bus.win_y), XW'(w.y));
            chk("xarray", bus.xarray_flat, w.data);
        end
    endtask

    task automatic do_reset(input bit v, input logic [P-1:0] d);
        reset         = 1'b1;
        bus.pix_valid = v;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = d;
        @(posedge clk);
        @(negedge clk);
        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        m_state = 0;
        m_col   = 0;
        m_row   = 0;
        m_err   = 1'b0;
        sb.delete();
        n_win  = 0;
        n_last = 0;
        chk("rst_win_valid", XW'(bus.win_valid), '0);
        chk("rst_win_last", XW'(bus.win_last), '0);
        chk("rst_win_x", XW'(bus.win_x), '0);
        chk("rst_win_y", XW'(bus.win_y), '0);
        chk("rst_xarray", bus.xarray_flat, '0);
        chk("rst_frame_err", XW'(bus.frame_err), '0);
    endtask

    task automatic frame(input int npix, input int off, input bit gaps, input bit probe);
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, P'($urandom_range(0, 127)));
            end
            step(1'b1, (i == 0), P'((i + off) % 128));
            if (probe && i == 104) begin
                chk("t1_first_vld", XW'(bus.win_valid), XW'(1));
                chk("t1_elem0", XW'(bus.xarray_flat[0 +: P]), XW'(0));
                chk("t1_elem40", XW'(bus.xarray_flat[40*P +: P]), XW'(52));
                chk("t1_elem80", XW'(bus.xarray_flat[80*P +: P]), XW'(104));
            end
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = '0;
        reset         = 1'b1;

        // Test 1: continuous full frame
        do_reset(1'b0, '0);
        frame(120, 0, 1'b0, 1'b1);
        chk("t1_count", XW'(n_win), XW'(8));
        chk("t1_last", XW'(n_last), XW'(1));

        // Test 2: random gaps on pix_valid
        do_reset(1'b0, '0);
        frame(120, 0, 1'b1, 1'b0);
        chk("t2_count", XW'(n_win), XW'(8));
        chk("t2_last", XW'(n_last), XW'(1));

        // Test 3: pixels without sof after reset
        do_reset(1'b0, '0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, P'(i));
        chk("t3_count", XW'(n_win), XW'(0));
        chk("t3_frame_err", XW'(bus.frame_err), XW'(ERR_EN));

        // Test 4: frame restart at pixel 50, then full frame
        do_reset(1'b0, '0);
        frame(50, 0, 1'b0, 1'b0);
        frame(120, 0, 1'b0, 1'b0);
        chk("t4_count", XW'(n_win), XW'(8));
        chk("t4_last", XW'(n_last), XW'(1));

        // Test 5: reset at pixel 110, remaining pixels without sof
        do_reset(1'b0, '0);
        frame(110, 0, 1'b0, 1'b0);
        chk("t5_pre_count", XW'(n_win), XW'(4));
        do_reset(1'b1, P'(110));
        for (int i = 111; i < 120; i++) step(1'b1, 1'b0, P'(i));
        chk("t5_post_count", XW'(n_win), XW'(0));

        // Test 6: two back-to-back frames with different content
        do_reset(1'b0, '0);
        frame(120, 0, 1'b0, 1'b0);
        frame(120, 37, 1'b0, 1'b0);
        chk("t6_count", XW'(n_win), XW'(16));
        chk("t6_last", XW'(n_last), XW'(2));

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
